// File: rtl/status_annunciator_pkg.sv
// Status codes and burst-sequencer state encodings for the status annunciator.
// Shared by the annunciator top and its bench.
package status_pkg;

  localparam logic [2:0] ST_ERR  = 3'b000;
  localparam logic [2:0] ST_OFF  = 3'b001;
  localparam logic [2:0] ST_ON   = 3'b010;
  localparam logic [2:0] ST_OPEN = 3'b011;
  localparam logic [2:0] ST_NONE = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2
  } burst_state_e;

endpackage

// File: rtl/status_annunciator_prescaler.sv
// Pulse prescaler: one-cycle tick every DIV enabled cycles, restartable via clr.
// tick is combinational from the count register; no backpressure.
module pulse_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));
  assign tick = en & ~clr & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/status_annunciator.sv
// Status code to LED pattern and alarm buzzer bursts; all outputs registered,
// one clk from state to LEDs/beep_busy/buzzer; no backpressure (pure sink of state).
module status_annunciator
  import status_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int BLINK_TICKS    = 250,
  parameter int BEEP_ON_TICKS  = 100,
  parameter int BEEP_OFF_TICKS = 100,
  parameter int ERR_BEEPS      = 3,
  parameter int OPEN_BEEPS     = 1,
  parameter int TONE_DIV       = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  output logic       led_err,
  output logic       led_off,
  output logic       led_on,
  output logic       led_open,
  output logic       buzzer,
  output logic       beep_busy
);

  localparam int TMAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RMAX = (ERR_BEEPS > OPEN_BEEPS) ? ERR_BEEPS : ((OPEN_BEEPS > 0) ? OPEN_BEEPS : 1);
  localparam int RW   = $clog2(RMAX + 1);
  localparam int BW   = $clog2(BLINK_TICKS + 1);

  logic          base_tick, tone_tick;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [2:0]    prev_state_q;
  burst_state_e  fsm_q, fsm_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          tone_q, tone_d;
  logic          chg, enter_on;
  logic          led_err_q, led_off_q, led_on_q, led_open_q, buzzer_q, busy_q;

  pulse_prescaler #(.DIV(TICK_DIV)) u_timebase (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (1'b0),
    .tick(base_tick)
  );

  // Tone restarts on every beep so each beep opens with a full high half-period.
  pulse_prescaler #(.DIV(TONE_DIV)) u_tone (
    .clk (clk),
    .rst (rst),
    .en  (fsm_q == BEEP_ON),
    .clr (enter_on),
    .tick(tone_tick)
  );

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (base_tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign chg = (state != prev_state_q);

  // A code change overrides any timer event, so a new alarm reloads mid-burst.
  always_comb begin
    fsm_d    = fsm_q;
    timer_d  = timer_q;
    rem_d    = rem_q;
    enter_on = 1'b0;
    if (chg) begin
      timer_d = '0;
      if (state == ST_ERR && ERR_BEEPS > 0) begin
        rem_d    = RW'(ERR_BEEPS);
        fsm_d    = BEEP_ON;
        enter_on = 1'b1;
      end else if (state == ST_OPEN && OPEN_BEEPS > 0) begin
        rem_d    = RW'(OPEN_BEEPS);
        fsm_d    = BEEP_ON;
        enter_on = 1'b1;
      end else begin
        rem_d = '0;
        fsm_d = IDLE;
      end
    end else if (base_tick) begin
      case (fsm_q)
        BEEP_ON: begin
          if (timer_q == TW'(BEEP_ON_TICKS - 1)) begin
            timer_d = '0;
            rem_d   = rem_q - 1'b1;
            fsm_d   = (rem_q == RW'(1)) ? IDLE : BEEP_OFF;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        BEEP_OFF: begin
          if (timer_q == TW'(BEEP_OFF_TICKS - 1)) begin
            timer_d  = '0;
            fsm_d    = BEEP_ON;
            enter_on = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tone_d = tone_q;
    if (enter_on) begin
      tone_d = 1'b0;
    end else if (tone_tick) begin
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b1;
      prev_state_q <= ST_NONE;
      fsm_q        <= IDLE;
      timer_q      <= '0;
      rem_q        <= '0;
      tone_q       <= 1'b0;
      led_err_q    <= 1'b0;
      led_off_q    <= 1'b0;
      led_on_q     <= 1'b0;
      led_open_q   <= 1'b0;
      buzzer_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      prev_state_q <= state;
      fsm_q        <= fsm_d;
      timer_q      <= timer_d;
      rem_q        <= rem_d;
      tone_q       <= tone_d;
      led_err_q    <= (state == ST_ERR) & blink_ph_q;
      led_off_q    <= (state == ST_OFF);
      led_on_q     <= (state == ST_ON);
      led_open_q   <= (state == ST_OPEN) & blink_ph_q;
      buzzer_q     <= (fsm_d == BEEP_ON) & ~tone_d;
      busy_q       <= (fsm_d != IDLE);
    end
  end

  assign led_err   = led_err_q;
  assign led_off   = led_off_q;
  assign led_on    = led_on_q;
  assign led_open  = led_open_q;
  assign buzzer    = buzzer_q;
  assign beep_busy = busy_q;

endmodule
